// File: rtl/mtr_drv.sv
// mtr_drv -- dual-side H-bridge PWM driver with over-current shutdown.
//
// An 11-bit free-running counter defines a 2048-cycle PWM period. Each side
// samples its signed speed command at the period wrap, converts it to
// sign/magnitude and drives its forward or reverse output high for
// <magnitude> cycles from the start of the period. A direction reversal
// out of a nonzero duty inserts one all-low dead period.
// A blanked, synchronized over-current flag is accumulated per period; after
// FAULT_LIM consecutive faulted periods the driver latches shutdown.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   lft_spd, rght_spd     signed 12-bit speed commands
//   OVR_I                 async over-current flag from the bridge
//   lft_fwd/lft_rev       left bridge PWM
//   rght_fwd/rght_rev     right bridge PWM
//   ovr_I_shtdwn          latched over-current shutdown

// One bridge side: latches the sampled command and generates its PWM pair.
module mtr_drv_side (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrap_i,     // this edge ends the period
  input  logic        kill_i,     // shutdown effective from the next cycle
  input  logic [10:0] nxt_cnt_i,  // counter value of the next cycle
  input  logic [11:0] spd_i,
  output logic        fwd_o,
  output logic        rev_o
);
  logic [10:0] mag_q, mag_d, smag;
  logic [11:0] neg;
  logic        dir_q, dir_d, sdir, on;

  always_comb begin
    neg   = 12'd0 - spd_i;
    sdir  = spd_i[11];
    // -2048 has no positive counterpart; saturate to full scale
    smag  = !sdir ? spd_i[10:0] : (neg[11] ? 11'h7FF : neg[10:0]);
    mag_d = mag_q;
    dir_d = dir_q;
    if (wrap_i) begin
      if (kill_i || smag == '0) begin
        mag_d = '0;
      end else if (sdir != dir_q && mag_q != '0) begin
        // reversal out of a driven period: one dead period, take the new
        // direction now and re-sample the magnitude at the next wrap
        mag_d = '0;
        dir_d = sdir;
      end else begin
        mag_d = smag;
        dir_d = sdir;
      end
    end
    // outputs are computed for the next cycle so they line up with cnt
    on = !kill_i && (nxt_cnt_i < mag_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
      dir_q <= 1'b0;
      fwd_o <= 1'b0;
      rev_o <= 1'b0;
    end else begin
      mag_q <= mag_d;
      dir_q <= dir_d;
      fwd_o <= on & ~dir_d;
      rev_o <= on & dir_d;
    end
  end
endmodule

module mtr_drv #(
  parameter int BLANK     = 128,
  parameter int FAULT_LIM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I,
  output logic        lft_fwd,
  output logic        lft_rev,
  output logic        rght_fwd,
  output logic        rght_rev,
  output logic        ovr_I_shtdwn
);
  localparam int          NUM_SIDES = 2;
  localparam int          FW        = $clog2(FAULT_LIM + 1);
  localparam logic [11:0] BLANK_W   = 12'(BLANK);

  logic [10:0]                cnt_q, cnt_d;
  logic                       wrap;
  logic                       ovr_s1_q, ovr_s2_q;
  logic                       flt_q, flt_d, flt_now;
  logic [FW-1:0]              fcnt_q, fcnt_d;
  logic                       shtdwn_q, shtdwn_d;
  logic [NUM_SIDES-1:0][11:0] spd;
  logic [NUM_SIDES-1:0]       fwd, rev;

  assign spd = {rght_spd, lft_spd};

  always_comb begin
    cnt_d    = cnt_q + 11'd1;
    wrap     = (cnt_q == 11'h7FF);
    // over-current only counts outside the blanking window while driving
    flt_now  = ovr_s2_q && ({1'b0, cnt_q} >= BLANK_W) && (|{fwd, rev});
    flt_d    = wrap ? 1'b0 : (flt_q | flt_now);
    fcnt_d   = fcnt_q;
    if (wrap) fcnt_d = (flt_q | flt_now) ? fcnt_q + FW'(1) : '0;
    shtdwn_d = shtdwn_q | (wrap && fcnt_d == FW'(FAULT_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      ovr_s1_q <= 1'b0;
      ovr_s2_q <= 1'b0;
      flt_q    <= 1'b0;
      fcnt_q   <= '0;
      shtdwn_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ovr_s1_q <= OVR_I;
      ovr_s2_q <= ovr_s1_q;
      flt_q    <= flt_d;
      fcnt_q   <= fcnt_d;
      shtdwn_q <= shtdwn_d;
    end
  end

  for (genvar g = 0; g < NUM_SIDES; g++) begin : g_side
    mtr_drv_side u_side (
      .clk       (clk),
      .rst_n     (rst_n),
      .wrap_i    (wrap),
      .kill_i    (shtdwn_d),
      .nxt_cnt_i (cnt_d),
      .spd_i     (spd[g]),
      .fwd_o     (fwd[g]),
      .rev_o     (rev[g])
    );
  end

  assign lft_fwd      = fwd[0];
  assign lft_rev      = rev[0];
  assign rght_fwd     = fwd[1];
  assign rght_rev     = rev[1];
  assign ovr_I_shtdwn = shtdwn_q;
endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv. Each PWM period is one transaction: the
// stimulus process runs a period-level reference model and queues the
// expected high-cycle counts and shutdown state; the monitor measures each
// period and pops/compares.
module tb_mtr_drv;
  localparam int BLANK     = 128;
  localparam int FAULT_LIM = 4;
  localparam int PER       = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] lft_spd = '0, rght_spd = '0;
  logic        OVR_I = 1'b0;
  logic        lft_fwd, lft_rev, rght_fwd, rght_rev, ovr_I_shtdwn;

  mtr_drv #(.BLANK(BLANK), .FAULT_LIM(FAULT_LIM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I        (OVR_I),
    .lft_fwd      (lft_fwd),
    .lft_rev      (lft_rev),
    .rght_fwd     (rght_fwd),
    .rght_rev     (rght_rev),
    .ovr_I_shtdwn (ovr_I_shtdwn)
  );

  always #5 clk = ~clk;

  typedef struct { int lf; int lr; int rf; int rr; int sh; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int nper   = 0;

  // per-period stimulus: speed to present for the next boundary, OVR mode
  // (0 = off, 1 = pulse during the blanking window only, 2 = held high)
  logic [11:0] ph_l[$], ph_r[$];
  int          ph_m[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Period-level side behaviour: signed command -> duty/direction.
  function automatic void side_model(input logic [11:0] s, inout bit dir,
                                     inout int duty);
    int v, m;
    bit sd;
    v  = $signed(s);
    sd = (v < 0);
    m  = sd ? -v : v;
    if (m > PER - 1) m = PER - 1;
    if (m == 0) duty = 0;
    else if (sd != dir && duty != 0) begin dir = sd; duty = 0; end
    else begin dir = sd; duty = m; end
  endfunction

  // Release reset, run n checked periods, then a partial period and an
  // asynchronous mid-period reset. Enters and leaves with rst_n low.
  task automatic run_phase(input int n, input int part);
    exp_t e;
    int   dl = 0, dr = 0, fc = 0;
    bit   ml = 0, mr = 0, shut = 0, flt;
    e = '{0, 0, 0, 0, 0};
    exp_q.push_back(e);
    nper = n;
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < n; k++) begin
      int midc;
      midc = $urandom_range(1, 2040);
      flt  = !shut && ph_m[k] == 2 && (dl > BLANK || dr > BLANK);
      fc   = flt ? fc + 1 : 0;
      if (fc == FAULT_LIM) shut = 1;
      if (shut) begin dl = 0; dr = 0; end
      else begin
        side_model(ph_l[k], ml, dl);
        side_model(ph_r[k], mr, dr);
      end
      if (k < n - 1) begin
        e.lf = ml ? 0 : dl;  e.lr = ml ? dl : 0;
        e.rf = mr ? 0 : dr;  e.rr = mr ? dr : 0;
        e.sh = int'(shut);
        exp_q.push_back(e);
      end
      for (int c = 0; c < PER; c++) begin
        @(negedge clk);
        if (c == 0) OVR_I = (ph_m[k] != 0);
        if (c == 64 && ph_m[k] == 1) OVR_I = 1'b0;
        if (c == midc) begin lft_spd = ph_l[k]; rght_spd = ph_r[k]; end
      end
    end
    for (int c = 0; c < part; c++) @(negedge clk);
    chk("pre_reset_shtdwn", int'(ovr_I_shtdwn), int'(shut));
    #3 rst_n = 1'b0;
    #1;
    chk("reset_pwm", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
    chk("reset_shtdwn", int'(ovr_I_shtdwn), 0);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: measure each period, check shape, pop and compare.
  initial begin
    forever begin
      @(posedge rst_n);
      for (int p = 0; p < nper; p++) begin
        int   lf, lr, rf, rr, sh, bad;
        logic [3:0] cur, prv;
        exp_t e;
        lf = 0; lr = 0; rf = 0; rr = 0; sh = 0; bad = 0; prv = '0;
        for (int c = 0; c < PER; c++) begin
          @(negedge clk);
          cur = {lft_fwd, lft_rev, rght_fwd, rght_rev};
          // pulses must start at cycle 0 and be contiguous
          if (c > 0 && (cur & ~prv) != 4'b0) bad++;
          if ((lft_fwd && lft_rev) || (rght_fwd && rght_rev)) bad++;
          lf += int'(lft_fwd);  lr += int'(lft_rev);
          rf += int'(rght_fwd); rr += int'(rght_rev);
          if (c == 1000) sh = int'(ovr_I_shtdwn);
          prv = cur;
        end
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("lft_fwd_cycles", lf, e.lf);
          chk("lft_rev_cycles", lr, e.lr);
          chk("rght_fwd_cycles", rf, e.rf);
          chk("rght_rev_cycles", rr, e.rr);
          chk("pwm_shape", bad, 0);
          chk("shtdwn", sh, e.sh);
        end
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] r0, r1, r2, r3;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_reset_pwm", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
    chk("init_reset_shtdwn", int'(ovr_I_shtdwn), 0);

    // Phase 1: +512, -2048, +300 -> -300 reversal, zero, small/odd values,
    // blanking-window OVR pulses with large duty.
    r0 = 12'($urandom_range(0, 4095));
    r1 = 12'($urandom_range(0, 4095));
    r2 = 12'($urandom_range(0, 4095));
    r3 = 12'($urandom_range(0, 4095));
    ph_l = {12'h200, 12'h200, 12'd300, 12'hED4, 12'hED4, r0, 12'h000, r1, 12'h7FF, 12'h400};
    ph_r = {12'h800, 12'h800, 12'h800, 12'h001, 12'hFFF, r2, r3, 12'h000, 12'h801, 12'h064};
    ph_m = {1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    run_phase(10, 100);

    // Phase 2: OVR held with +1000 -> shutdown latched, cleared by reset.
    ph_l = {}; ph_r = {}; ph_m = {};
    for (int i = 0; i < 7; i++) begin
      ph_l.push_back(12'd1000); ph_r.push_back(12'd1000); ph_m.push_back(2);
    end
    run_phase(7, 500);

    // Phase 3: 3 faulted, 1 clean, 3 faulted -> no shutdown.
    ph_l = {}; ph_r = {};
    for (int i = 0; i < 9; i++) begin
      ph_l.push_back(12'd1000); ph_r.push_back(12'd1000);
    end
    ph_m = {2, 2, 2, 2, 0, 2, 2, 2, 0};
    run_phase(9, 50);

    // Phase 4: random commands and OVR modes.
    ph_l = {}; ph_r = {}; ph_m = {};
    for (int i = 0; i < 8; i++) begin
      ph_l.push_back(12'($urandom_range(0, 4095)));
      ph_r.push_back(12'($urandom_range(0, 4095)));
      ph_m.push_back(int'($urandom_range(0, 2)));
    end
    run_phase(8, int'($urandom_range(1, 2000)));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 SHALL have parameter BLANK, default 128: PWM counts after period start during which the over-current input is ignored.
REQ-002 SHALL have parameter FAULT_LIM, default 4: consecutive faulted PWM periods that trigger shutdown.
REQ-003 SHALL have port clk, input, 1: system clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port lft_spd, input, 12: signed two's-complement left wheel speed command.
REQ-006 SHALL have port rght_spd, input, 12: signed two's-complement right wheel speed command.
REQ-007 SHALL have port OVR_I, input, 1: over-current flag from the motor bridge; asynchronous to clk; active-high.
REQ-008 SHALL have port lft_fwd / lft_rev, output, 1 each: left bridge forward / reverse PWM.
REQ-009 SHALL have port rght_fwd / rght_rev, output, 1 each: right bridge forward / reverse PWM.
REQ-010 SHALL have port ovr_I_shtdwn, output, 1: latched over-current shutdown indication.

Function
REQ-011 SHALL run an 11-bit free-running period counter cnt, 0..2047, wrapping 2047->0; one PWM period = 2048 clk cycles.
REQ-012 SHALL sample lft_spd/rght_spd only on the edge where cnt wraps 2047->0; mid-period input changes have no effect until the next period.
REQ-013 SHALL convert each sample to sign-magnitude: dir = bit 11 (0 fwd, 1 rev); mag = |spd|, with -2048 saturated to 2047.
REQ-014 SHALL, per side, drive the active-direction output high for exactly mag consecutive cycles starting at the first cycle of the period, then low for the rest of the period; the inactive-direction output stays low.
REQ-015 SHALL make all PWM outputs registered and glitch-free; a uniform one-cycle offset from cnt is allowed.
REQ-016 SHALL on mag==0 drive both outputs of that side low for the full period and keep the previously latched dir unchanged.
REQ-017 SHALL, when a sampled dir differs from the latched dir and the previous period's duty was nonzero, insert one dead period: both outputs of that side low for 2048 cycles and dir updated. The new magnitude takes effect only at the next boundary, which re-samples the input.
REQ-018 SHALL never assert fwd and rev of the same side in the same cycle.
REQ-019 SHALL synchronize OVR_I through two flops before use.
REQ-020 SHALL set a per-period fault flag when the synchronized OVR_I is high while cnt >= BLANK and at least one PWM output is high; the flag is ignored otherwise.
REQ-021 SHALL at each period boundary increment a fault counter if the flag was set, otherwise clear the counter to 0; the flag clears at every boundary.
REQ-022 SHALL latch shutdown when the fault counter reaches FAULT_LIM: ovr_I_shtdwn=1, all four PWM outputs low from the next cycle onward. Only rst_n clears shutdown.
REQ-023 SHALL keep cnt running during shutdown; speed inputs are ignored.

Reset
REQ-024 SHALL on rst_n low asynchronously force cnt=0, all PWM outputs=0, latched mag=0, latched dir=fwd, fault counter=0, fault flag=0, sync flops=0, ovr_I_shtdwn=0.
REQ-025 SHALL hold the first period after reset release at duty 0, with outputs low; commands apply from the first 2047->0 wrap.
REQ-026 SHALL treat reset mid-period as above, with no partial pulse after release.

Verification
REQ-027 lft_spd=12'h200 held -> lft_fwd high exactly 512 cycles per 2048-cycle period; lft_rev always 0.
REQ-028 rght_spd=12'h800 (-2048) -> rght_rev high 2047 of 2048 cycles; rght_fwd 0.
REQ-029 lft_spd steps +300 to -300 mid-period -> current period finishes at 300 fwd, next period both left outputs low, following period lft_rev high 300 cycles.
REQ-030 OVR_I pulsed high only for cnt<128 every period with spd=+1000 -> no shutdown after 10 periods.
REQ-031 OVR_I held high with spd=+1000 -> ovr_I_shtdwn rises at the 4th period boundary and all outputs stay low; rst_n pulse clears it.
REQ-032 Faults in 3 consecutive periods, then 1 clean period, then 3 more faulted periods -> no shutdown.
